ws2812_frame_driver: RTL and testbench

Parametrised single-wire serial driver for WS2812-style addressable LED strips. Accepts a complete frame of NUM_LEDS 24-bit pixels through a start/busy handshake. Applies a global 8-bit brightness scale per colour channel, serialises the frame with cycle-exact high/low bit timing, then holds the line low for the latch (reset) period. Sits between the frame/pattern generator and the strip data pin, and supports frames of any length and any system clock through parameters.

---
 rtl/ws2812_frame_driver.sv | 144 ++++++++++++++
 tb/tb_ws2812_frame_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_driver.sv
// WS2812 single-wire frame serialiser: captures a frame of NUM_LEDS GRB pixels,
// scales each channel by a global brightness and emits cycle-exact bit timing plus latch.
module ws2812_frame_driver #(
   parameter int NUM_LEDS = 6,
   parameter int T0H      = 8,
   parameter int T0L      = 17,
   parameter int T1H      = 18,
   parameter int T1L      = 7,
   parameter int TRESET   = 1200
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [24*NUM_LEDS-1:0]   frame,
   input  logic [7:0]               brightness,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     dout
);

   localparam int PIX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int TMAX_A = (T0H > T0L) ? T0H : T0L;
   localparam int TMAX_B = (T1H > T1L) ? T1H : T1L;
   localparam int TMAX_C = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int TMAX = (TMAX_C > TRESET) ? TMAX_C : TRESET;
   localparam int TW = $clog2(TMAX + 1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

   state_t                  state;
   logic [24*NUM_LEDS-1:0]  frame_q;
   logic [7:0]              bright_q;
   logic [23:0]             shifter;
   logic [4:0]              bit_cnt;
   logic [PIX_W-1:0]        pix_cnt;
   logic [TW-1:0]           tcnt;

   logic [23:0]             first_word;
   logic [23:0]             next_raw;
   logic [23:0]             next_word;
   logic                    last_bit;

   // Per-channel scale: keep the top byte of c * (brightness + 1).
   function automatic logic [23:0] scale(input logic [23:0] px, input logic [7:0] b);
      logic [15:0] prod;
      logic [23:0] res;
      res = '0;
      for (int ch = 0; ch < 3; ch++) begin
         prod = {8'd0, px[8*ch +: 8]} * ({8'd0, b} + 16'd1);
         res[8*ch +: 8] = prod[15:8];
      end
      return res;
   endfunction

   function automatic logic [TW-1:0] high_len(input logic b);
      return b ? TW'(T1H - 1) : TW'(T0H - 1);
   endfunction

   function automatic logic [TW-1:0] low_len(input logic b);
      return b ? TW'(T1L - 1) : TW'(T0L - 1);
   endfunction

   always_comb begin
      next_raw = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         if (PIX_W'(i) == pix_cnt + PIX_W'(1)) next_raw = frame_q[24*i +: 24];
      end
      first_word = scale(frame[23:0], brightness);
      next_word  = (bit_cnt == 5'd23) ? scale(next_raw, bright_q) : {shifter[22:0], 1'b0};
      last_bit   = (bit_cnt == 5'd23) && (pix_cnt == PIX_W'(NUM_LEDS - 1));
   end

   // tcnt holds the remaining cycles minus one of the current phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         dout     <= 1'b0;
         frame_q  <= '0;
         bright_q <= '0;
         shifter  <= '0;
         bit_cnt  <= '0;
         pix_cnt  <= '0;
         tcnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= HIGH;
                  busy     <= 1'b1;
                  dout     <= 1'b1;
                  frame_q  <= frame;
                  bright_q <= brightness;
                  shifter  <= first_word;
                  bit_cnt  <= '0;
                  pix_cnt  <= '0;
                  tcnt     <= high_len(first_word[23]);
               end
            end
            HIGH: begin
               if (tcnt == '0) begin
                  state <= LOW;
                  dout  <= 1'b0;
                  tcnt  <= low_len(shifter[23]);
               end else begin
                  tcnt <= tcnt - TW'(1);
               end
            end
            LOW: begin
               if (tcnt != '0) begin
                  tcnt <= tcnt - TW'(1);
               end else if (last_bit) begin
                  state <= LATCH;
                  tcnt  <= TW'(TRESET - 1);
               end else begin
                  state   <= HIGH;
                  dout    <= 1'b1;
                  shifter <= next_word;
                  tcnt    <= high_len(next_word[23]);
                  if (bit_cnt == 5'd23) begin
                     bit_cnt <= '0;
                     pix_cnt <= pix_cnt + PIX_W'(1);
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
            end
            LATCH: begin
               if (tcnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  tcnt <= tcnt - TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Self-checking bench for ws2812_frame_driver with a two-pixel frame: compares the
// dout waveform sample-by-sample against a waveform built from the frame's scaled bits.
module tb_ws2812_frame_driver;

   localparam int NLED = 2;
   localparam int FRAME_CYCLES = 24 * NLED * 25 + 1200;

   logic              clk;
   logic              rst;
   logic [24*NLED-1:0] frame;
   logic [7:0]        brightness;
   logic              start;
   logic              busy;
   logic              done;
   logic              dout;

   int vectors;
   int miscompares;

   typedef struct {
      logic [47:0] frame;
      logic [7:0]  bright;
      logic [47:0] expWire;
      string       name;
   } vec_t;

   vec_t table_v[5];

   ws2812_frame_driver #(
      .NUM_LEDS(NLED), .T0H(8), .T0L(17), .T1H(18), .T1L(7), .TRESET(1200)
   ) dut (
      .clk(clk), .rst(rst), .frame(frame), .brightness(brightness),
      .start(start), .busy(busy), .done(done), .dout(dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wire order result: pixel 0 occupies the top 24 bits, sent MSB first.
   function automatic logic [47:0] modelWire(input logic [47:0] f, input logic [7:0] b);
      logic [47:0] res;
      int c;
      res = '0;
      for (int p = 0; p < NLED; p++) begin
         for (int ch = 0; ch < 3; ch++) begin
            c = int'(f[24*p + 8*ch +: 8]);
            res[24*(NLED-1-p) + 8*ch +: 8] = 8'((c * (int'(b) + 1)) / 256);
         end
      end
      return res;
   endfunction

   task automatic applyStimulus(input logic [47:0] f, input logic [7:0] b, input bit hold);
      @(negedge clk);
      frame = f;
      brightness = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   task automatic checkOutput(input logic [47:0] expWire, input string name, input bit checkAfter);
      bit expWave[$];
      int k;
      int bad;
      int firstBad;
      bit ended;
      bit b;
      expWave = {};
      for (int j = 0; j < 48; j++) begin
         b = expWire[47-j];
         repeat (b ? 18 : 8) expWave.push_back(1'b1);
         repeat (b ? 7 : 17) expWave.push_back(1'b0);
      end
      repeat (1200) expWave.push_back(1'b0);
      k = 0; bad = 0; firstBad = -1; ended = 0;
      for (int c = 0; c < FRAME_CYCLES + 500; c++) begin
         @(negedge clk);
         if (!busy) begin
            ended = 1;
            break;
         end
         if (k >= expWave.size() || dout !== expWave[k] || done !== 1'b0) begin
            bad++;
            if (firstBad < 0) firstBad = k;
         end
         k++;
      end
      vectors++;
      if (!ended || k != expWave.size()) begin
         miscompares++;
         $display("[TB] FAIL busy_len_%s: got %0d cycles, want %0d", name, k, expWave.size());
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("[TB] FAIL wave_%s: got %0d bad samples (first at %0d), want 0 (wire %h)",
                  name, bad, firstBad, expWire);
      end
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL done_%s: got done=%b at busy fall, want 1", name, done);
      end
      if (checkAfter) begin
         @(negedge clk);
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0 || dout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL pulse_%s: got done=%b busy=%b dout=%b, want 0 0 0",
                     name, done, busy, dout);
         end
      end
   endtask

   task automatic checkQuiet(input string name, input int cycles);
      int bad;
      bad = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("[TB] FAIL quiet_%s: got %0d active cycles, want 0", name, bad);
      end
   endtask

   task automatic resetMidFrame(input int delay, input string name);
      applyStimulus(48'h123456_ABCDEF, 8'd255, 1'b0);
      repeat (delay) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rst_%s: got dout=%b busy=%b done=%b, want 0 0 0",
                  name, dout, busy, done);
      end
      rst = 1'b0;
      checkQuiet(name, 1300);
   endtask

   initial begin
      logic [47:0] fA, fB;
      logic [7:0]  bA, bB;
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      start = 1'b0;
      frame = '0;
      brightness = '0;

      table_v[0] = '{48'h000000_A500FF, 8'd255, 48'hA500FF_000000, "a500ff"};
      table_v[1] = '{48'h102040_FF8002, 8'd127, 48'h7F4001_081020, "half"};
      table_v[2] = '{48'hFFFFFF_FFFFFF, 8'd0,   48'h000000_000000, "dark"};
      table_v[3] = '{48'h123456_ABCDEF, 8'd255, 48'hABCDEF_123456, "ident"};
      table_v[4] = '{48'h0C0804_FF8040, 8'd63,  48'h3F2010_030201, "quarter"};

      // Start pulses while reset is held must not launch a frame.
      repeat (3) @(negedge clk);
      start = 1'b1;
      frame = 48'hFFFFFF_FFFFFF;
      brightness = 8'd255;
      repeat (3) @(negedge clk);
      vectors++;
      if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got dout=%b busy=%b done=%b, want 0 0 0", dout, busy, done);
      end
      start = 1'b0;
      rst = 1'b0;
      checkQuiet("idle", 50);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(table_v[i].frame, table_v[i].bright, 1'b0);
         checkOutput(table_v[i].expWire, table_v[i].name, 1'b1);
      end

      for (int i = 0; i < 4; i++) begin
         fA = {$urandom, $urandom};
         bA = 8'($urandom_range(0, 255));
         applyStimulus(fA, bA, 1'b0);
         checkOutput(modelWire(fA, bA), $sformatf("rand%0d", i), 1'b1);
      end

      // A start pulse with new data mid-frame is ignored.
      fA = {$urandom, $urandom};
      bA = 8'($urandom_range(0, 255));
      applyStimulus(fA, bA, 1'b0);
      fork
         checkOutput(modelWire(fA, bA), "restart", 1'b1);
         begin
            repeat (500) @(negedge clk);
            frame = ~fA;
            brightness = ~bA;
            start = 1'b1;
            repeat (20) @(negedge clk);
            start = 1'b0;
         end
      join

      // start held through done: the next frame begins one cycle after done.
      fA = {$urandom, $urandom};
      bA = 8'($urandom_range(0, 255));
      fB = {$urandom, $urandom};
      bB = 8'($urandom_range(0, 255));
      applyStimulus(fA, bA, 1'b1);
      fork
         begin
            checkOutput(modelWire(fA, bA), "b2bA", 1'b0);
            checkOutput(modelWire(fB, bB), "b2bB", 1'b1);
         end
         begin
            repeat (300) @(negedge clk);
            frame = fB;
            brightness = bB;
            repeat (FRAME_CYCLES) @(negedge clk);
            start = 1'b0;
         end
      join

      resetMidFrame(24 * 25 + 10 * 25 + 5, "bit10");
      resetMidFrame(48 * 25 + 600, "latch");

      fA = {$urandom, $urandom};
      bA = 8'($urandom_range(0, 255));
      applyStimulus(fA, bA, 1'b0);
      checkOutput(modelWire(fA, bA), "post_rst", 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
